// File: rtl/word_serializer16_pkg.sv
// Shared widths, FSM encoding and select-index helpers for the word serializer.
package word_serializer16_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // First bit index sent for a given bit order.
  function automatic logic [SEL_W-1:0] first_idx(input logic msb_first);
    return msb_first ? SEL_W'(WORD_W - 1) : SEL_W'(0);
  endfunction

  // Final bit index of a word for a given bit order.
  function automatic logic [SEL_W-1:0] last_idx(input logic msb_first);
    return msb_first ? SEL_W'(0) : SEL_W'(WORD_W - 1);
  endfunction

endpackage

// File: rtl/word_serializer16_mux.sv
// 16:1 single-bit mux used for serializer bit selection.
module mux16to1_1 (
  input  logic [15:0] a,
  input  logic [3:0]  s,
  output logic        y
);

  assign y = a[s];

endmodule

// File: rtl/word_serializer16.sv
// Parallel-to-serial stage: latches a 16-bit word and walks the mux select
// through it one bit per serial transfer.
module word_serializer16
  import word_serializer16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_data,
  output logic              ser_last,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  localparam logic [SEL_W-1:0] FIRST_IDX = first_idx(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST_IDX  = last_idx(MSB_FIRST);

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] hold;
  logic [WORD_W-1:0] hold_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic              in_ready_nx;
  logic              ser_valid_nx;
  logic              ser_last_nx;
  logic              busy_nx;

  mux16to1_1 u_mux (
    .a (hold),
    .s (sel),
    .y (ser_data)
  );

  // State, hold, select and all decoded flags are registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold      <= '0;
      sel       <= FIRST_IDX;
      in_ready  <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      hold      <= hold_nx;
      sel       <= sel_nx;
      in_ready  <= in_ready_nx;
      ser_valid <= ser_valid_nx;
      ser_last  <= ser_last_nx;
      busy      <= busy_nx;
    end
  end

  // Next-state logic; flags are decoded from the next state so they line up
  // with the registered state on the following cycle.
  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    sel_nx   = sel;

    unique case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          hold_nx  = in_data;
          sel_nx   = FIRST_IDX;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ser_ready) begin
          if (ser_last) begin
            state_nx = ST_IDLE;
          end else if (MSB_FIRST) begin
            sel_nx = sel - SEL_W'(1);
          end else begin
            sel_nx = sel + SEL_W'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    in_ready_nx  = (state_nx == ST_IDLE);
    ser_valid_nx = (state_nx == ST_SEND);
    busy_nx      = (state_nx == ST_SEND);
    ser_last_nx  = (state_nx == ST_SEND) && (sel_nx == LAST_IDX);
  end

endmodule

// File: tb/tb_word_serializer16.sv
// Directed bench for word_serializer16: LSB-first and MSB-first instances
// driven by the same stimulus.
module tb_word_serializer16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        ser_ready;

  logic        in_ready, ser_valid, ser_data, ser_last, busy;
  logic [3:0]  sel;
  logic        in_ready_m, ser_valid_m, ser_data_m, ser_last_m, busy_m;
  logic [3:0]  sel_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  word_serializer16 #(.MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_data(ser_data), .ser_last(ser_last), .sel(sel), .busy(busy)
  );

  word_serializer16 #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
    .ser_data(ser_data_m), .ser_last(ser_last_m), .sel(sel_m), .busy(busy_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer a word at the current negedge; returns at the negedge of the first bit.
  task automatic accept(input logic [15:0] w, input bit keep_valid);
    bit done = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    chk("accept_timeout", 32'(done), 32'd1);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Walk the 16 bits of w; stall 3 cycles at bits in stall_mask; poke input at poke_at.
  task automatic run_word(input logic [15:0] w, input logic [15:0] stall_mask,
                          input int poke_at, input bit msb_chk);
    logic [15:0] rx = '0;
    int lasts = 0;
    for (int i = 0; i < 16; i++) begin
      if (poke_at >= 0 && i == poke_at + 1) in_valid = 1'b0;
      if (i == poke_at) begin
        in_valid = 1'b1;
        in_data  = ~w;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
      end
      if (stall_mask[i]) begin
        ser_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk($sformatf("stall_sel_b%0d", i), 32'(sel), 32'(i));
          chk($sformatf("stall_data_b%0d", i), 32'(ser_data), 32'(w[i]));
          chk($sformatf("stall_last_b%0d", i), 32'(ser_last), 32'(i == 15));
        end
        ser_ready = 1'b1;
      end
      chk($sformatf("valid_b%0d", i), 32'({ser_valid, busy, in_ready}), 32'b110);
      chk($sformatf("sel_b%0d", i), 32'(sel), 32'(i));
      chk($sformatf("data_b%0d", i), 32'(ser_data), 32'(w[i]));
      chk($sformatf("last_b%0d", i), 32'(ser_last), 32'(i == 15));
      if (msb_chk) begin
        chk($sformatf("m_sel_b%0d", i), 32'(sel_m), 32'(15 - i));
        chk($sformatf("m_data_b%0d", i), 32'(ser_data_m), 32'(w[15 - i]));
        chk($sformatf("m_last_b%0d", i), 32'(ser_last_m), 32'(i == 15));
      end
      rx[i] = ser_data;
      if (ser_last) lasts++;
      @(negedge clk);
    end
    chk("word_rx", 32'(rx), 32'(w));
    chk("last_count", 32'(lasts), 32'd1);
    chk("end_idle", 32'({ser_valid, busy, in_ready, ser_last}), 32'b0010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ser_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_flags", 32'({ser_valid, ser_last, busy}), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_sel_m", 32'(sel_m), 32'd15);
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_ignore_valid", 32'(ser_valid), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'({in_ready, in_ready_m}), 32'b11);
    chk("rel_flags", 32'({ser_valid, ser_last, busy, ser_data}), 32'd0);
    chk("rel_sel", 32'(sel), 32'd0);

    // LSB-first and MSB-first on F0F0
    accept(16'hF0F0, 1'b0);
    run_word(16'hF0F0, 16'h0000, -1, 1'b1);

    // Backpressure at bits 0, 7 and 15
    accept(16'hA5C3, 1'b0);
    run_word(16'hA5C3, 16'h8081, -1, 1'b0);

    // Back-to-back: second accept one cycle after the last transfer
    accept(16'h0001, 1'b1);
    in_data = 16'h8000;
    run_word(16'h0001, 16'h0000, -1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accept", 32'({ser_valid, busy}), 32'b11);
    run_word(16'h8000, 16'h0000, -1, 1'b0);

    // Input poke mid-word has no effect
    accept(16'h1234, 1'b0);
    run_word(16'h1234, 16'h0000, 6, 1'b0);
    @(negedge clk);
    chk("poke_no_accept", 32'({ser_valid, in_ready}), 32'b01);

    // Reset at bit 5
    accept(16'hFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pre_rst_last_b%0d", i), 32'(ser_last), 32'd0);
      @(negedge clk);
    end
    chk("pre_rst_sel", 32'(sel), 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_flags", 32'({in_ready, ser_valid, ser_last, busy}), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_hold", 32'(ser_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'({in_ready, ser_valid, ser_last, busy}), 32'b1000);
    accept(16'h0F0F, 1'b0);
    run_word(16'h0F0F, 16'h0000, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
